icache_direct: RTL and testbench



---
 rtl/icache_direct.sv | 92 +++++++++
 tb/tb_icache_direct.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-line instruction cache with single-outstanding memory fetch.
module icache_direct #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_i,
    input  logic              clr_i,
    input  logic              pc_valid_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_ready_o,
    output logic              instr_valid_o,
    output logic [31:0]       instr_o,
    output logic              mc_fet_ena_o,
    output logic [ADDR_W-1:0] mc_addr_o,
    input  logic              mc_valid_i,
    input  logic [31:0]       mc_data_i
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                  state_q;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q [LINES];
    logic [31:0]             data_q [LINES];
    logic [INDEX_BITS-1:0]   miss_idx_q;
    logic [TAG_W-1:0]        miss_tag_q;
    logic                    pend_drop_q;
    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_W-1:0]        tag;
    logic                    hit;
    logic                    accept;
    logic                    fill;

    assign idx        = pc_i[INDEX_BITS+1:2];
    assign tag        = pc_i[ADDR_W-1:INDEX_BITS+2];
    assign hit        = valid_q[idx] && (tag_q[idx] == tag);
    assign pc_ready_o = (state_q == IDLE);
    assign accept     = pc_valid_i && pc_ready_o && !clr_i;
    assign fill       = rdy_i && (state_q == MISS) && mc_valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            mc_fet_ena_o  <= 1'b0;
            mc_addr_o     <= '0;
            miss_idx_q    <= '0;
            miss_tag_q    <= '0;
            pend_drop_q   <= 1'b0;
        end else if (rdy_i) begin
            instr_valid_o <= 1'b0;
            if (state_q == IDLE) begin
                if (accept && hit) begin
                    instr_o       <= data_q[idx];
                    instr_valid_o <= 1'b1;
                end else if (accept) begin
                    mc_fet_ena_o <= 1'b1;
                    mc_addr_o    <= pc_i & ~ADDR_W'(3);
                    miss_idx_q   <= idx;
                    miss_tag_q   <= tag;
                    pend_drop_q  <= 1'b0;
                    state_q      <= MISS;
                end
            end else begin
                if (clr_i) pend_drop_q <= 1'b1;
                if (mc_valid_i) begin
                    valid_q[miss_idx_q] <= 1'b1;
                    mc_fet_ena_o        <= 1'b0;
                    state_q             <= IDLE;
                    // a redirected fill still lands in the array; only the response is suppressed
                    if (!pend_drop_q && !clr_i) begin
                        instr_o       <= mc_data_i;
                        instr_valid_o <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fill) begin
            tag_q[miss_idx_q]  <= miss_tag_q;
            data_q[miss_idx_q] <= mc_data_i;
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed scenarios with a response scoreboard popped by an independent monitor.
module tb_icache_direct;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clr = 1'b0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic        mc_fet_ena;
    logic [31:0] mc_addr;
    logic        mc_valid = 1'b0;
    logic [31:0] mc_data = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    icache_direct dut (
        .clk(clk), .rst(rst), .rdy_i(rdy), .clr_i(clr),
        .pc_valid_i(pc_valid), .pc_i(pc), .pc_ready_o(pc_ready),
        .instr_valid_o(instr_valid), .instr_o(instr),
        .mc_fet_ena_o(mc_fet_ena), .mc_addr_o(mc_addr),
        .mc_valid_i(mc_valid), .mc_data_i(mc_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // monitor: every response must match the oldest expected instruction
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_instr_valid", instr, 32'hxxxx_xxxx);
            end else begin
                check("instr", instr, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [31:0] a);
        check("pc_ready_before_req", {31'd0, pc_ready}, 32'd1);
        pc_valid = 1'b1;
        pc = a;
        @(negedge clk);
        pc_valid = 1'b0;
    endtask

    task automatic hit(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back(d);
        issue(a);
        check("hit_no_fetch", {31'd0, mc_fet_ena}, 32'd0);
        check("hit_pc_ready", {31'd0, pc_ready}, 32'd1);
    endtask

    // clr_at: miss cycle on which clr pulses (-1 none); frz: freeze rdy for 5 cycles mid-miss
    task automatic miss(input logic [31:0] a, input logic [31:0] d, input int hold, input int clr_at, input bit frz);
        issue(a);
        check("miss_fet_ena", {31'd0, mc_fet_ena}, 32'd1);
        check("miss_addr", mc_addr, {a[31:2], 2'b00});
        check("miss_pc_ready", {31'd0, pc_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            clr = (i == clr_at);
            if (frz && i == 1) begin
                rdy = 1'b0;
                pc_valid = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("frz_fet_ena", {31'd0, mc_fet_ena}, 32'd1);
                    check("frz_addr", mc_addr, {a[31:2], 2'b00});
                    check("frz_pc_ready", {31'd0, pc_ready}, 32'd0);
                end
                rdy = 1'b1;
                pc_valid = 1'b0;
            end
            @(negedge clk);
            clr = 1'b0;
            check("hold_fet_ena", {31'd0, mc_fet_ena}, 32'd1);
            check("hold_addr", mc_addr, {a[31:2], 2'b00});
        end
        if (clr_at < 0) exp_q.push_back(d);
        mc_valid = 1'b1;
        mc_data = d;
        @(negedge clk);
        mc_valid = 1'b0;
        check("fill_fet_drop", {31'd0, mc_fet_ena}, 32'd0);
        check("fill_pc_ready", {31'd0, pc_ready}, 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_pc_ready", {31'd0, pc_ready}, 32'd1);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_fet_ena", {31'd0, mc_fet_ena}, 32'd0);
        check("rst_addr", mc_addr, 32'd0);
        // 1 cold miss, 2 immediate hit on the freshly filled line
        miss(32'h0000_0004, 32'h0050_0093, 3, -1, 1'b0);
        hit(32'h0000_0004, 32'h0050_0093);
        hit(32'h0000_0007, 32'h0050_0093);
        // 3 conflict on index 1, then the evicted address refetches back-to-back
        miss(32'h0000_0104, 32'hFFF0_0113, 2, -1, 1'b0);
        miss(32'h0000_0004, 32'h0050_0093, 1, -1, 1'b0);
        // 4 redirect mid-miss drops the response but the line is still filled
        miss(32'h0000_0008, 32'h0000_0013, 3, 1, 1'b0);
        hit(32'h0000_0008, 32'h0000_0013);
        // clr in IDLE blocks acceptance
        clr = 1'b1;
        pc_valid = 1'b1;
        pc = 32'h0000_0010;
        @(negedge clk);
        clr = 1'b0;
        pc_valid = 1'b0;
        check("idle_clr_no_fetch", {31'd0, mc_fet_ena}, 32'd0);
        // stray mc_valid in IDLE must not write line 3
        mc_valid = 1'b1;
        mc_data = 32'hDEAD_BEEF;
        @(negedge clk);
        mc_valid = 1'b0;
        // 5 rdy freeze mid-miss
        miss(32'h0000_000C, 32'h00A0_0193, 3, -1, 1'b1);
        hit(32'h0000_000C, 32'h00A0_0193);
        // 6 reset mid-miss clears the array
        issue(32'h0000_0204);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_fet_ena", {31'd0, mc_fet_ena}, 32'd0);
        check("rstmid_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rstmid_pc_ready", {31'd0, pc_ready}, 32'd1);
        miss(32'h0000_0004, 32'h0050_0093, 2, -1, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
